// File: rtl/cnu_rd_phase_ctrl.sv
// Read-side CNU sequencer: one init handshake, then up to MAX_ITER read bursts each closed by a finish handshake.
// Optional early termination on syndrome pass is compiled in with `define CNU_RD_EARLY_TERM_EN.
module cnu_rd_phase_ctrl #(
  parameter int RD_LEN   = 4,
  parameter int ADDR_W   = 4,
  parameter int MAX_ITER = 8,
  parameter int ITER_W   = 4
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic              decode_start_i,
  input  logic              early_term_i,
  input  logic              init_load_i,
  input  logic              pipe_load_i,
  output logic              cnu_init_load_en_o,
  output logic              cnu_rd_finish_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              busy_o,
  output logic              decode_done_o
);

  typedef enum logic [2:0] {
    IDLE,
    INIT_REQ,
    INIT_REL,
    READ,
    FIN_REQ,
    FIN_REL,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RD_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ITER_W-1:0] MAX_IT    = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        il_sync;
  logic [1:0]        pl_sync;
  logic              il_s;
  logic              pl_s;
  logic              term;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ITER_W-1:0] iter_nxt;
  logic [ITER_W-1:0] iter_inc;

  assign il_s = il_sync[1];
  assign pl_s = pl_sync[1];

`ifdef CNU_RD_EARLY_TERM_EN
  assign term = early_term_i;
`else
  logic early_term_unused;
  assign early_term_unused = early_term_i;
  assign term              = 1'b0;
`endif

  // Saturating increment so the count can never pass MAX_ITER.
  assign iter_inc = (iter_cnt_o == MAX_IT) ? iter_cnt_o : iter_cnt_o + ITER_ONE;

  always_comb begin
    state_nxt = state;
    addr_nxt  = '0;
    iter_nxt  = iter_cnt_o;
    case (state)
      IDLE: begin
        if (decode_start_i) begin
          state_nxt = INIT_REQ;
          iter_nxt  = '0;
        end
      end
      INIT_REQ: if (il_s) state_nxt = INIT_REL;
      INIT_REL: if (!il_s) state_nxt = READ;
      READ: begin
        if (rd_addr_o == LAST_ADDR) state_nxt = FIN_REQ;
        else                        addr_nxt  = rd_addr_o + ADDR_ONE;
      end
      FIN_REQ: if (pl_s) state_nxt = FIN_REL;
      FIN_REL: begin
        if (!pl_s) begin
          iter_nxt  = iter_inc;
          state_nxt = ((iter_inc == MAX_IT) || term) ? DONE : READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      state              <= IDLE;
      il_sync            <= '0;
      pl_sync            <= '0;
      rd_addr_o          <= '0;
      iter_cnt_o         <= '0;
      cnu_init_load_en_o <= 1'b0;
      cnu_rd_finish_o    <= 1'b0;
      rd_en_o            <= 1'b0;
      busy_o             <= 1'b0;
      decode_done_o      <= 1'b0;
    end else begin
      state              <= state_nxt;
      il_sync            <= {il_sync[0], init_load_i};
      pl_sync            <= {pl_sync[0], pipe_load_i};
      rd_addr_o          <= addr_nxt;
      iter_cnt_o         <= iter_nxt;
      cnu_init_load_en_o <= (state_nxt == INIT_REQ);
      cnu_rd_finish_o    <= (state_nxt == FIN_REQ);
      rd_en_o            <= (state_nxt == READ);
      busy_o             <= (state_nxt != IDLE);
      decode_done_o      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_cnu_rd_phase_ctrl.sv
// Directed bench for cnu_rd_phase_ctrl with RD_LEN=4, MAX_ITER=3 and a delayed-acknowledge model.
module tb_cnu_rd_phase_ctrl;
  localparam int RD_LEN   = 4;
  localparam int ADDR_W   = 4;
  localparam int MAX_ITER = 3;
  localparam int ITER_W   = 4;
`ifdef CNU_RD_EARLY_TERM_EN
  localparam int ET_ITER = 2;
`else
  localparam int ET_ITER = 3;
`endif

  logic              read_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              decode_start_i = 1'b0;
  logic              early_term_i = 1'b0;
  logic              init_load_i = 1'b0;
  logic              pipe_load_i = 1'b0;
  logic              cnu_init_load_en_o;
  logic              cnu_rd_finish_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [ITER_W-1:0] iter_cnt_o;
  logic              busy_o;
  logic              decode_done_o;

  cnu_rd_phase_ctrl #(
    .RD_LEN(RD_LEN), .ADDR_W(ADDR_W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
  ) dut (
    .read_clk(read_clk), .rstn(rstn), .decode_start_i(decode_start_i),
    .early_term_i(early_term_i), .init_load_i(init_load_i), .pipe_load_i(pipe_load_i),
    .cnu_init_load_en_o(cnu_init_load_en_o), .cnu_rd_finish_o(cnu_rd_finish_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .iter_cnt_o(iter_cnt_o),
    .busy_o(busy_o), .decode_done_o(decode_done_o)
  );

  always #5 read_clk = ~read_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Acknowledge model: raise ack 6 cycles into a request, drop it 6 cycles after the request falls.
  bit auto_ack = 1'b0;
  int ci_on = 0, ci_off = 0, cp_on = 0, cp_off = 0;
  initial forever begin
    @(posedge read_clk);
    #1;
    if (!auto_ack) begin
      ci_on = 0; ci_off = 0; cp_on = 0; cp_off = 0;
    end else begin
      if (cnu_init_load_en_o) begin
        ci_off = 0;
        if (!init_load_i) begin ci_on++; if (ci_on == 6) init_load_i = 1'b1; end
      end else begin
        ci_on = 0;
        if (init_load_i) begin ci_off++; if (ci_off == 6) begin init_load_i = 1'b0; ci_off = 0; end end
      end
      if (cnu_rd_finish_o) begin
        cp_off = 0;
        if (!pipe_load_i) begin cp_on++; if (cp_on == 6) pipe_load_i = 1'b1; end
      end else begin
        cp_on = 0;
        if (pipe_load_i) begin cp_off++; if (cp_off == 6) begin pipe_load_i = 1'b0; cp_off = 0; end end
      end
    end
  end

  bit   mon_en = 1'b0;
  int   q_addr[$];
  int   n_init = 0, n_fin = 0, n_done = 0;
  logic prev_en = 1'b0, prev_fin = 1'b0;
  initial forever begin
    @(negedge read_clk);
    if (mon_en) begin
      if (rd_en_o) q_addr.push_back(int'(rd_addr_o));
      if (cnu_init_load_en_o && !prev_en) n_init++;
      if (cnu_rd_finish_o && !prev_fin) n_fin++;
      if (decode_done_o) n_done++;
    end
    prev_en  = cnu_init_load_en_o;
    prev_fin = cnu_rd_finish_o;
  end

  task automatic clear_mon();
    q_addr.delete();
    n_init = 0; n_fin = 0; n_done = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge read_clk);
  endtask

  function automatic logic cond(input int k);
    case (k)
      0:       cond = decode_done_o;
      1:       cond = cnu_rd_finish_o;
      2:       cond = rd_en_o;
      3:       cond = (iter_cnt_o == 1);
      4:       cond = !cnu_rd_finish_o;
      default: cond = 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int k, input string tag);
    int n = 0;
    while (!cond(k) && n < 3000) begin
      @(negedge read_clk);
      n++;
    end
    check(tag, 32'(cond(k)), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, 32'(cnu_init_load_en_o), 0);
    check({tag, "_fin"}, 32'(cnu_rd_finish_o), 0);
    check({tag, "_rd_en"}, 32'(rd_en_o), 0);
    check({tag, "_addr"}, 32'(rd_addr_o), 0);
    check({tag, "_iter"}, 32'(iter_cnt_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_done"}, 32'(decode_done_o), 0);
  endtask

  task automatic pulse_start();
    decode_start_i = 1'b1;
    tick(1);
    decode_start_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_all_zero("reset");
    rstn = 1'b1;
    tick(1);
    check("idle_busy", 32'(busy_o), 0);

    // Full decode with the acknowledge model.
    clear_mon(); mon_en = 1'b1; auto_ack = 1'b1;
    pulse_start();
    check("start_init_en", 32'(cnu_init_load_en_o), 1);
    check("start_busy", 32'(busy_o), 1);
    wait_for(0, "run_done");
    check("run_iter", 32'(iter_cnt_o), 3);
    tick(3);
    mon_en = 1'b0;
    check("run_n_init", 32'(n_init), 1);
    check("run_n_fin", 32'(n_fin), 3);
    check("run_n_done", 32'(n_done), 1);
    check("run_n_addr", 32'(q_addr.size()), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("run_addr%0d", i), (i < q_addr.size()) ? 32'(q_addr[i]) : 32'd99, 32'(i % 4));
    check("run_idle_busy", 32'(busy_o), 0);
    check("run_iter_hold", 32'(iter_cnt_o), 3);
    auto_ack = 1'b0;

    // Manual acks: propagation timing and a stale pipe ack.
    pulse_start();
    check("man_iter_clr", 32'(iter_cnt_o), 0);
    check("man_en", 32'(cnu_init_load_en_o), 1);
    tick(2);
    init_load_i = 1'b1;
    tick(2);
    check("init_en_hold", 32'(cnu_init_load_en_o), 1);
    tick(1);
    check("init_en_fall", 32'(cnu_init_load_en_o), 0);
    init_load_i = 1'b0;
    pipe_load_i = 1'b1;
    tick(2);
    check("rd_en_wait", 32'(rd_en_o), 0);
    tick(1);
    check("rd_en_rise", 32'(rd_en_o), 1);
    check("rd_addr0", 32'(rd_addr_o), 0);
    tick(3);
    check("rd_addr3", 32'(rd_addr_o), 3);
    tick(1);
    check("stale_finreq", 32'(cnu_rd_finish_o), 1);
    check("stale_rd_off", 32'(rd_en_o), 0);
    tick(1);
    check("stale_finreq_1cyc", 32'(cnu_rd_finish_o), 0);
    check("stale_busy", 32'(busy_o), 1);
    tick(5);
    check("stale_hold_rd", 32'(rd_en_o), 0);
    check("stale_hold_iter", 32'(iter_cnt_o), 0);
    pipe_load_i = 1'b0;
    tick(2);
    check("finrel_wait", 32'(rd_en_o), 0);
    tick(1);
    check("finrel_to_read", 32'(rd_en_o), 1);
    check("finrel_iter", 32'(iter_cnt_o), 1);
    tick(4);
    check("mid_finreq", 32'(cnu_rd_finish_o), 1);
    rstn = 1'b0;
    tick(1);
    check_all_zero("midrst");
    rstn = 1'b1;

    // Fresh start after the mid-run reset.
    clear_mon(); mon_en = 1'b1; auto_ack = 1'b1;
    pulse_start();
    check("fresh_en", 32'(cnu_init_load_en_o), 1);
    check("fresh_iter", 32'(iter_cnt_o), 0);
    wait_for(0, "fresh_done");
    check("fresh_iter_end", 32'(iter_cnt_o), 3);
    tick(2);
    mon_en = 1'b0;
    check("fresh_n_init", 32'(n_init), 1);

    // Early termination raised during the second FIN_REL.
    pulse_start();
    wait_for(3, "et_iter1");
    wait_for(1, "et_fin2_req");
    wait_for(4, "et_fin2_rel");
    early_term_i = 1'b1;
    wait_for(0, "et_done");
    early_term_i = 1'b0;
    check("et_iter", 32'(iter_cnt_o), 32'(ET_ITER));
    tick(2);

    // Start pulses in READ and in DONE are ignored.
    clear_mon(); mon_en = 1'b1;
    pulse_start();
    wait_for(2, "ign_read");
    pulse_start();
    check("ign_read_iter", 32'(iter_cnt_o), 0);
    check("ign_read_en", 32'(cnu_init_load_en_o), 0);
    check("ign_read_rd", 32'(rd_en_o), 1);
    wait_for(0, "ign_done");
    pulse_start();
    check("ign_done_busy", 32'(busy_o), 0);
    check("ign_done_pulse", 32'(decode_done_o), 0);
    check("ign_done_en", 32'(cnu_init_load_en_o), 0);
    tick(3);
    mon_en = 1'b0;
    check("ign_n_done", 32'(n_done), 1);
    check("ign_iter", 32'(iter_cnt_o), 3);
    check("ign_idle", 32'(busy_o), 0);
    auto_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
